i2c_write_sequencer: RTL and testbench

Transaction-level sequencer directly upstream of the I2C byte writer. Accepts a write request (7-bit slave address plus 0–15 payload bytes over a valid/ready byte stream) and drives the byte writer's command/go/data interface. It issues START, the address byte with R/W=0, each payload byte MSB-first, then STOP. It also serialises each byte into the writer's one-bit `data` input, advancing on the writer's active-low `load` strobe.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_write_sequencer_if.sv | 33 +++
 rtl/i2c_tx_shift.sv | 35 +++
 rtl/i2c_write_sequencer.sv | 168 ++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte-writer and bit-writer command codes,
// write-sequencer state encoding and the default payload length limit.
package i2c_pkg;

  localparam int MAX_LEN_DEFAULT = 15;

  localparam logic [2:0] BW_CMD_IDLE  = 3'b000;
  localparam logic [2:0] BW_CMD_START = 3'b001;
  localparam logic [2:0] BW_CMD_ACK   = 3'b010;
  localparam logic [2:0] BW_CMD_DATA  = 3'b011;
  localparam logic [2:0] BW_CMD_STOP  = 3'b100;
  localparam logic [2:0] BW_CMD_NACK  = 3'b101;

  localparam logic [1:0] BIT_CMD_IDLE  = 2'b00;
  localparam logic [1:0] BIT_CMD_START = 2'b01;
  localparam logic [1:0] BIT_CMD_STOP  = 2'b10;
  localparam logic [1:0] BIT_CMD_DATA  = 2'b11;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_START,
    SEQ_ADDR,
    SEQ_FETCH,
    SEQ_DATA,
    SEQ_ACKCHK,
    SEQ_STOP
  } seq_state_e;

endpackage

// File: rtl/i2c_write_sequencer_if.sv
// Request/payload stream and byte-writer bus of the I2C write sequencer.
// The master modport is the sequencer side, the slave modport its environment.
interface i2c_write_sequencer_if;

  logic       req;
  logic [6:0] addr;
  logic [3:0] len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] bw_command;
  logic       bw_go;
  logic       bw_data;
  logic       bw_finish;
  logic       bw_load_n;
  logic       ack_req;
  logic       ack_done;
  logic       ack_nack;

  modport master (
    input  req, addr, len, wr_data, wr_valid, bw_finish, bw_load_n, ack_done, ack_nack,
    output wr_ready, busy, done, error, bw_command, bw_go, bw_data, ack_req
  );

  modport slave (
    output req, addr, len, wr_data, wr_valid, bw_finish, bw_load_n, ack_done, ack_nack,
    input  wr_ready, busy, done, error, bw_command, bw_go, bw_data, ack_req
  );

endinterface

// File: rtl/i2c_tx_shift.sv
// Transmit shift register for one I2C byte: parallel load, shift left on the
// byte writer's load strobe, MSB drives the serial data line.
module i2c_tx_shift (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] load_value_i,
  input  logic       shift_i,
  output logic       msb_o
);

  logic [7:0] shreg_q;
  logic [7:0] shreg_d;

  // A load always wins over a shift; vacated LSBs fill with zero.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = load_value_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[7];

endmodule

// File: rtl/i2c_write_sequencer.sv
// I2C write sequencer: START, address+W, payload bytes, STOP via the byte writer.
// Optional slave-ACK checking after every byte is enabled by I2C_SEQ_ACK_CHECK_EN.
module i2c_write_sequencer
  import i2c_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset_n,
  i2c_write_sequencer_if.master         bus
);

  seq_state_e state_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       wr_ready_q;
  logic       bw_go_q;
  logic [2:0] bw_command_q;

  logic       accept_req;
  logic       accept_byte;
  logic       more_bytes;
  logic [3:0] len_capped;
  logic       shift_load;
  logic       shift_en;
  logic [7:0] shift_value;

  assign accept_req  = (state_q == SEQ_IDLE) && bus.req;
  assign accept_byte = wr_ready_q && bus.wr_valid;
  assign more_bytes  = (cnt_q != 4'd0);
  assign len_capped  = (32'(bus.len) > MAX_LEN) ? 4'(MAX_LEN) : bus.len;

  assign shift_load  = accept_req || accept_byte;
  assign shift_value = accept_req ? {bus.addr, 1'b0} : bus.wr_data;
  assign shift_en    = ((state_q == SEQ_ADDR) || (state_q == SEQ_DATA)) && !bus.bw_load_n;

  i2c_tx_shift u_shift (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_i       (shift_load),
    .load_value_i (shift_value),
    .shift_i      (shift_en),
    .msb_o        (bus.bw_data)
  );

`ifdef I2C_SEQ_ACK_CHECK_EN
  logic ack_req_q;
  logic err_q;
  logic error_q;
`endif

  // Each command state spends its first cycle with go low, raising go together
  // with the new command, so the byte writer always sees an idle gap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEQ_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_ready_q   <= 1'b0;
      bw_go_q      <= 1'b0;
      bw_command_q <= BW_CMD_IDLE;
`ifdef I2C_SEQ_ACK_CHECK_EN
      ack_req_q    <= 1'b0;
      err_q        <= 1'b0;
      error_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef I2C_SEQ_ACK_CHECK_EN
      error_q <= 1'b0;
`endif
      case (state_q)
        SEQ_IDLE: begin
          if (bus.req) begin
            cnt_q        <= len_capped;
            busy_q       <= 1'b1;
            bw_go_q      <= 1'b1;
            bw_command_q <= BW_CMD_START;
            state_q      <= SEQ_START;
`ifdef I2C_SEQ_ACK_CHECK_EN
            err_q        <= 1'b0;
`endif
          end
        end
        SEQ_START: begin
          if (bus.bw_finish) begin
            bw_go_q <= 1'b0;
            state_q <= SEQ_ADDR;
          end
        end
        SEQ_ADDR, SEQ_DATA: begin
          if (!bw_go_q) begin
            bw_go_q      <= 1'b1;
            bw_command_q <= BW_CMD_DATA;
          end else if (bus.bw_finish) begin
            bw_go_q <= 1'b0;
`ifdef I2C_SEQ_ACK_CHECK_EN
            ack_req_q <= 1'b1;
            state_q   <= SEQ_ACKCHK;
`else
            wr_ready_q <= more_bytes;
            state_q    <= more_bytes ? SEQ_FETCH : SEQ_STOP;
`endif
          end
        end
        SEQ_FETCH: begin
          if (accept_byte) begin
            wr_ready_q <= 1'b0;
            if (more_bytes) begin
              cnt_q <= cnt_q - 4'd1;
            end
            state_q <= SEQ_DATA;
          end
        end
`ifdef I2C_SEQ_ACK_CHECK_EN
        SEQ_ACKCHK: begin
          if (bus.ack_done) begin
            ack_req_q <= 1'b0;
            if (bus.ack_nack) begin
              err_q   <= 1'b1;
              state_q <= SEQ_STOP;
            end else begin
              wr_ready_q <= more_bytes;
              state_q    <= more_bytes ? SEQ_FETCH : SEQ_STOP;
            end
          end
        end
`endif
        SEQ_STOP: begin
          if (!bw_go_q) begin
            bw_go_q      <= 1'b1;
            bw_command_q <= BW_CMD_STOP;
          end else if (bus.bw_finish) begin
            bw_go_q      <= 1'b0;
            bw_command_q <= BW_CMD_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= SEQ_IDLE;
`ifdef I2C_SEQ_ACK_CHECK_EN
            error_q      <= err_q;
            err_q        <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bw_go      = bw_go_q;
  assign bus.bw_command = bw_command_q;

`ifdef I2C_SEQ_ACK_CHECK_EN
  assign bus.ack_req = ack_req_q;
  assign bus.error   = error_q;
`else
  assign bus.ack_req = 1'b0;
  assign bus.error   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: byte-writer model logs every command and the
// serialised byte, compared against a frame-level reference of each transaction.
module tb_i2c_write_sequencer;
  import i2c_pkg::*;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  i2c_write_sequencer_if bus ();

  i2c_write_sequencer #(.MAX_LEN(15)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checkCount = 0;
  int passCount  = 0;
  int protoErrors = 0;

  logic [2:0] cmdLog[$];
  logic [7:0] byteLog[$];
  logic [2:0] expCmd[$];
  logic [7:0] expByte[$];
  int         expHandshakes;
  logic       expError;

  bit         mActive = 1'b0;
  bit         mGapSeen = 1'b1;
  bit         mLoadNext;
  logic [2:0] mCmd;
  logic [7:0] mByte;
  int         mBit;
  int         mTick;

  // Byte-writer model: START/STOP finish after a short delay; DATA samples the
  // serial line, strobes load low after each bit and finishes after eight bits.
  initial begin
    bus.bw_finish = 1'b0;
    bus.bw_load_n = 1'b1;
    forever begin
      @(negedge clock);
      bus.bw_finish = 1'b0;
      bus.bw_load_n = 1'b1;
      if (!reset_n) begin
        mActive  = 1'b0;
        mGapSeen = 1'b1;
      end else if (!mActive) begin
        if (!bus.bw_go) begin
          mGapSeen = 1'b1;
        end else begin
          if (!mGapSeen) protoErrors++;
          mGapSeen  = 1'b0;
          mActive   = 1'b1;
          mCmd      = bus.bw_command;
          mByte     = 8'h00;
          mBit      = 0;
          mTick     = 0;
          mLoadNext = 1'b0;
          if (mCmd == BW_CMD_DATA) begin
            mByte     = {mByte[6:0], bus.bw_data};
            mBit      = 1;
            mLoadNext = 1'b1;
          end
        end
      end else begin
        if (!bus.bw_go || (bus.bw_command !== mCmd)) protoErrors++;
        if (mCmd == BW_CMD_DATA) begin
          if (mLoadNext) begin
            bus.bw_load_n = 1'b0;
            mLoadNext     = 1'b0;
          end else if (mBit < 8) begin
            mByte     = {mByte[6:0], bus.bw_data};
            mBit++;
            mLoadNext = 1'b1;
          end else begin
            bus.bw_finish = 1'b1;
            cmdLog.push_back(mCmd);
            byteLog.push_back(mByte);
            mActive = 1'b0;
          end
        end else begin
          mTick++;
          if (mTick >= 2) begin
            bus.bw_finish = 1'b1;
            cmdLog.push_back(mCmd);
            byteLog.push_back(mByte);
            mActive = 1'b0;
          end
        end
      end
    end
  end

`ifdef I2C_SEQ_ACK_CHECK_EN
  int ackTick = 0;
  int ackIdx = 0;
  int nackPlan = -1;

  // Slave-ACK model: answers each ack request two cycles later; the ACK slot
  // numbered nackPlan (0 = address byte) answers NACK.
  initial begin
    bus.ack_done = 1'b0;
    bus.ack_nack = 1'b0;
    forever begin
      @(negedge clock);
      bus.ack_done = 1'b0;
      bus.ack_nack = 1'b0;
      if (!reset_n || !bus.ack_req) begin
        ackTick = 0;
      end else begin
        ackTick++;
        if (ackTick == 2) begin
          bus.ack_done = 1'b1;
          bus.ack_nack = (ackIdx == nackPlan);
          ackIdx++;
        end
      end
    end
  end
`else
  initial begin
    bus.ack_done = 1'b0;
    bus.ack_nack = 1'b0;
  end
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] outVec();
    return {bus.busy, bus.done, bus.error, bus.wr_ready, bus.bw_go,
            bus.bw_data, bus.ack_req, bus.bw_command};
  endfunction

  // Reference frames: START, address with W, payload bytes up to any NACK, STOP.
  task automatic buildExpected(input logic [6:0] a, input logic [7:0] bytes[$], input int nackAt);
    int sent;
    sent = (nackAt < 0 || nackAt > bytes.size()) ? bytes.size() : nackAt;
    expCmd.push_back(BW_CMD_START);
    expByte.push_back(8'h00);
    expCmd.push_back(BW_CMD_DATA);
    expByte.push_back(8'(a * 2));
    for (int i = 0; i < sent; i++) begin
      expCmd.push_back(BW_CMD_DATA);
      expByte.push_back(bytes[i]);
    end
    expCmd.push_back(BW_CMD_STOP);
    expByte.push_back(8'h00);
    expHandshakes += sent;
    expError = (nackAt >= 0) && (nackAt <= bytes.size());
  endtask

  task automatic applyStimulus(input string tag, input logic [6:0] a, input logic [3:0] n, input bit hold);
    @(negedge clock);
    bus.req  = 1'b1;
    bus.addr = a;
    bus.len  = n;
    @(negedge clock);
    checkOutput({tag, "_startTiming"}, {bus.busy, bus.bw_go, bus.bw_command}, {1'b1, 1'b1, BW_CMD_START});
    if (!hold) bus.req = 1'b0;
  endtask

  task automatic serveTxn(input logic [7:0] bytes[$], input int stallCycles,
                          output int doneCnt, output logic errOut, output logic busyAtDone,
                          output int hs, output int gwr, output int readyCycles);
    int idx = 0;
    int stall = stallCycles;
    doneCnt = 0; errOut = 1'b0; busyAtDone = 1'b0; hs = 0; gwr = 0; readyCycles = 0;
    for (int cyc = 0; cyc < 3000 && doneCnt == 0; cyc++) begin
      @(negedge clock);
      if (bus.done) begin
        doneCnt++;
        errOut     = bus.error;
        busyAtDone = bus.busy;
      end
      if (bus.wr_ready) readyCycles++;
      if (bus.wr_ready && bus.bw_go) gwr++;
      if (bus.wr_ready && stall > 0) begin
        stall--;
        bus.wr_valid = 1'b0;
      end else if (idx < bytes.size()) begin
        bus.wr_data  = bytes[idx];
        bus.wr_valid = ($urandom_range(0, 3) != 0);
        if (bus.wr_valid && bus.wr_ready) begin
          idx++;
          hs++;
        end
      end else begin
        bus.wr_valid = 1'b0;
      end
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic checkLog(input string tag);
    checkOutput({tag, "_frameCount"}, cmdLog.size(), expCmd.size());
    for (int i = 0; i < expCmd.size() && i < cmdLog.size(); i++) begin
      checkOutput($sformatf("%s_cmd%0d", tag, i), cmdLog[i], expCmd[i]);
      checkOutput($sformatf("%s_byte%0d", tag, i), byteLog[i], expByte[i]);
    end
  endtask

  task automatic clearLogs();
    cmdLog.delete(); byteLog.delete(); expCmd.delete(); expByte.delete();
    expHandshakes = 0;
    expError = 1'b0;
  endtask

  task automatic runTxn(input string tag, input logic [6:0] a, input logic [7:0] bytes[$],
                        input int stall, input int nackAt);
    int doneCnt, hs, gwr, readyCycles;
    logic errOut, busyAtDone;
    clearLogs();
    buildExpected(a, bytes, nackAt);
`ifdef I2C_SEQ_ACK_CHECK_EN
    ackIdx = 0;
    nackPlan = nackAt;
`endif
    applyStimulus(tag, a, 4'(bytes.size()), 1'b0);
    serveTxn(bytes, stall, doneCnt, errOut, busyAtDone, hs, gwr, readyCycles);
    checkOutput({tag, "_done"}, doneCnt, 1);
    checkOutput({tag, "_error"}, errOut, expError);
    checkOutput({tag, "_busyAtDone"}, busyAtDone, 1'b0);
    checkOutput({tag, "_handshakes"}, hs, expHandshakes);
    checkOutput({tag, "_readySeen"}, readyCycles != 0, expHandshakes != 0);
    checkOutput({tag, "_goWhileFetch"}, gwr, 0);
    checkOutput({tag, "_protocol"}, protoErrors, 0);
    checkLog(tag);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [6:0] a;
    int n, waitCyc, doneCnt, hs, gwr, readyCycles;
    logic errOut, busyAtDone;

    reset_n = 1'b0;
    bus.req = 1'b0; bus.addr = '0; bus.len = '0;
    bus.wr_data = '0; bus.wr_valid = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("resetState", outVec(), 10'b0);
    reset_n = 1'b1;

    $display("[TB] directed: addr 0x50, two bytes");
    q = '{8'hA5, 8'h3C};
    runTxn("basic", 7'h50, q, 0, -1);

    $display("[TB] directed: zero-length write");
    q.delete();
    runTxn("len0", 7'h7F, q, 0, -1);

    $display("[TB] directed: payload withheld in FETCH");
    q = '{8'h81};
    runTxn("stall", 7'h2A, q, 50, -1);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 8; t++) begin
      q.delete();
      a = 7'($urandom_range(0, 127));
      n = (t == 0) ? 15 : $urandom_range(0, 15);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      runTxn($sformatf("rand%0d", t), a, q, $urandom_range(0, 4), -1);
    end

    $display("[TB] reset during address byte");
    clearLogs();
    applyStimulus("midReset", 7'h33, 4'd2, 1'b0);
    waitCyc = 0;
    while (!(mActive && mCmd == BW_CMD_DATA && mBit >= 4) && waitCyc < 500) begin
      @(negedge clock);
      waitCyc++;
    end
    checkOutput("midResetReached", waitCyc < 500, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("midResetOutputs", outVec(), 10'b0);
    repeat (2) @(negedge clock);
    checkOutput("midResetNoDone", outVec(), 10'b0);
    reset_n = 1'b1;
    q = '{8'hC3, 8'h5A};
    runTxn("afterReset", 7'h11, q, 0, -1);

    $display("[TB] request held across done");
    clearLogs();
    q = '{8'h69};
    buildExpected(7'h44, q, -1);
    buildExpected(7'h44, q, -1);
`ifdef I2C_SEQ_ACK_CHECK_EN
    ackIdx = 0;
    nackPlan = -1;
`endif
    applyStimulus("held1", 7'h44, 4'd1, 1'b1);
    serveTxn(q, 0, doneCnt, errOut, busyAtDone, hs, gwr, readyCycles);
    checkOutput("held1_done", doneCnt, 1);
    @(negedge clock);
    checkOutput("held2_restart", {bus.busy, bus.bw_go, bus.bw_command}, {1'b1, 1'b1, BW_CMD_START});
    bus.req = 1'b0;
    serveTxn(q, 0, doneCnt, errOut, busyAtDone, hs, gwr, readyCycles);
    checkOutput("held2_done", doneCnt, 1);
    checkOutput("held_protocol", protoErrors, 0);
    checkLog("held");

`ifdef I2C_SEQ_ACK_CHECK_EN
    $display("[TB] NACK on address byte");
    q = '{8'h01, 8'h02, 8'h03};
    runTxn("nackAddr", 7'h5D, q, 0, 0);
    q = '{8'hF0, 8'h0F, 8'hAA};
    runTxn("nackByte1", 7'h21, q, 0, 2);
`endif

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
